// File: rtl/ws2812_driver.sv
// WS2812 single-wire serialiser: sends the GRB word {level_g, level_r, level_b}
// to every LED of a NUM_LEDS chain, then holds the line low for the latch gap.
module ws2812_driver #(
   parameter int NUM_LEDS = 1,
   parameter int T_BIT    = 13,
   parameter int T0H      = 4,
   parameter int T1H      = 8,
   parameter int T_RESET  = 500
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] level_r,
   input  logic [7:0] level_g,
   input  logic [7:0] level_b,
   input  logic       start,
   output logic       dout,
   output logic       busy,
   output logic       done
);

   // state   | meaning
   // S_IDLE  | line low, waiting for start
   // S_BIT   | shifting out bits of the captured word, one per T_BIT cycles
   // S_LATCH | line low for T_RESET cycles so the chain latches
   // S_DONE  | one-cycle done pulse; a start here launches the next frame

   localparam int CW = (T_BIT > 1) ? $clog2(T_BIT) : 1;
   localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int RW = (T_RESET > 1) ? $clog2(T_RESET) : 1;

   localparam logic [CW-1:0] CYC_LAST = CW'(T_BIT - 1);
   localparam logic [CW-1:0] HI0      = CW'(T0H);
   localparam logic [CW-1:0] HI1      = CW'(T1H);
   localparam logic [LW-1:0] LED_LAST = LW'(NUM_LEDS - 1);
   localparam logic [RW-1:0] LAT_LOAD = RW'(T_RESET - 1);

   if (NUM_LEDS < 1 || T0H < 1 || T1H <= T0H || T_BIT <= T1H || T_RESET < 1) begin : g_param_err
      $error("ws2812_driver: illegal timing parameters (need 0<T0H<T1H<T_BIT, NUM_LEDS>=1, T_RESET>=1)");
   end

   typedef enum logic [1:0] {S_IDLE, S_BIT, S_LATCH, S_DONE} state_t;

   state_t        state;
   logic [23:0]   word_cap;
   logic [23:0]   shreg;
   logic [CW-1:0] cyc;
   logic [CW-1:0] cyc_nx;
   logic [CW-1:0] txh;
   logic [4:0]    bit_cnt;
   logic [LW-1:0] led_cnt;
   logic [RW-1:0] lat_cnt;

   always_comb begin
      cyc_nx = cyc + 1'b1;
      txh    = shreg[23] ? HI1 : HI0;
   end

   // Outputs are registered for the cycle being entered, so dout never sees
   // a combinational path from the inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         word_cap <= '0;
         shreg    <= '0;
         cyc      <= '0;
         bit_cnt  <= '0;
         led_cnt  <= '0;
         lat_cnt  <= '0;
         dout     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done <= 1'b0;
               if (start) begin
                  word_cap <= {level_g, level_r, level_b};
                  shreg    <= {level_g, level_r, level_b};
                  cyc      <= '0;
                  bit_cnt  <= '0;
                  led_cnt  <= '0;
                  busy     <= 1'b1;
                  dout     <= 1'b1;
                  state    <= S_BIT;
               end else begin
                  busy  <= 1'b0;
                  dout  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            S_BIT: begin
               if (cyc == CYC_LAST) begin
                  cyc <= '0;
                  if (bit_cnt == 5'd23) begin
                     bit_cnt <= '0;
                     if (led_cnt == LED_LAST) begin
                        lat_cnt <= LAT_LOAD;
                        dout    <= 1'b0;
                        state   <= S_LATCH;
                     end else begin
                        led_cnt <= led_cnt + 1'b1;
                        shreg   <= word_cap;
                        dout    <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     shreg   <= {shreg[22:0], 1'b0};
                     dout    <= 1'b1;
                  end
               end else begin
                  cyc  <= cyc_nx;
                  dout <= (cyc_nx < txh);
               end
            end
            S_LATCH: begin
               dout <= 1'b0;
               if (lat_cnt == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: begin
               dout  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_driver.sv
// Bench for ws2812_driver: a single-LED and a two-LED instance, a per-cycle
// scoreboard driven by a frame-position model, plus directed corner cases.
module tb_ws2812_driver;

   localparam int T_BIT   = 13;
   localparam int T0H     = 4;
   localparam int T1H     = 8;
   localparam int T_RESET = 500;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] level_r = '0;
   logic [7:0] level_g = '0;
   logic [7:0] level_b = '0;
   logic       start0 = 1'b0;
   logic       start1 = 1'b0;
   logic       dout0, busy0, done0;
   logic       dout1, busy1, done1;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ws2812_driver #(.NUM_LEDS(1), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)) dut0 (
      .clk(clk), .reset(reset), .level_r(level_r), .level_g(level_g), .level_b(level_b),
      .start(start0), .dout(dout0), .busy(busy0), .done(done0));

   ws2812_driver #(.NUM_LEDS(2), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_RESET(T_RESET)) dut1 (
      .clk(clk), .reset(reset), .level_r(level_r), .level_g(level_g), .level_b(level_b),
      .start(start1), .dout(dout1), .busy(busy1), .done(done1));

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: frame position t (1 = first cycle after the accepting edge)
   // maps directly to {dout, busy, done}.
   function automatic int frame_len(int n);
      return 24 * n * T_BIT + T_RESET + 1;
   endfunction

   function automatic logic [2:0] exp_out(int t, logic [23:0] w, int n);
      int nb, b, c;
      logic bv;
      nb = 24 * n * T_BIT;
      if (t <= nb) begin
         b  = (t - 1) / T_BIT;
         c  = (t - 1) % T_BIT;
         bv = w[23 - (b % 24)];
         return {(c < (bv ? T1H : T0H)), 1'b1, 1'b0};
      end else if (t <= nb + T_RESET) begin
         return 3'b010;
      end
      return 3'b001;
   endfunction

   logic        m_act0 = 1'b0, m_act1 = 1'b0;
   int          m_t0 = 0, m_t1 = 0;
   logic [23:0] m_w0 = '0, m_w1 = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) m_act0 = 1'b0;
      else if (m_act0 && m_t0 < frame_len(1)) m_t0++;
      else if (start0) begin
         m_act0 = 1'b1; m_t0 = 1; m_w0 = {level_g, level_r, level_b};
      end else m_act0 = 1'b0;
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) m_act1 = 1'b0;
      else if (m_act1 && m_t1 < frame_len(2)) m_t1++;
      else if (start1) begin
         m_act1 = 1'b1; m_t1 = 1; m_w1 = {level_g, level_r, level_b};
      end else m_act1 = 1'b0;
   end

   always @(negedge clk) begin
      check("sb_led1", {dout0, busy0, done0}, m_act0 ? exp_out(m_t0, m_w0, 1) : 3'b000);
      check("sb_led2", {dout1, busy1, done1}, m_act1 ? exp_out(m_t1, m_w1, 2) : 3'b000);
   end

   // Called at the negedge where start was raised; returns per-bit decoded
   // high widths (1 = T1H, 0 = T0H) and the cycle of the done pulse.
   task automatic measure(input int inst, input int nbits, output logic [47:0] mask,
                          output int bad, output int done_k);
      int w;
      logic d, dn;
      mask = '0; bad = 0; done_k = 0; w = 0;
      @(negedge clk);
      if (inst == 0) start0 = 1'b0; else start1 = 1'b0;
      for (int k = 1; k <= 4000 && done_k == 0; k++) begin
         if (k > 1) @(negedge clk);
         d  = (inst == 0) ? dout0 : dout1;
         dn = (inst == 0) ? done0 : done1;
         if (k <= nbits * T_BIT) begin
            if ((k - 1) % T_BIT == 0) w = 0;
            w += int'(d);
            if ((k - 1) % T_BIT == T_BIT - 1) begin
               if (w == T1H) mask[nbits - 1 - (k - 1) / T_BIT] = 1'b1;
               else if (w != T0H) bad++;
            end
         end
         if (dn) done_k = k;
      end
   endtask

   typedef struct {
      logic [7:0]  g, r, b;
      logic [23:0] mask;
      int          done_k;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic [47:0] mask;
      int bad, dk, cnt_done, cnt_hi;

      vecs[0] = '{8'hFF, 8'h00, 8'h00, 24'hFF0000, 813};
      vecs[1] = '{8'h80, 8'h01, 8'hA5, 24'h8001A5, 813};
      vecs[2] = '{8'h00, 8'hAA, 8'hFF, 24'h00AAFF, 813};
      vecs[3] = '{8'h3C, 8'hC3, 8'h00, 24'h3CC300, 813};

      // reset held with start high
      start0 = 1'b1; start1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_hold", {dout0, busy0, done0, dout1, busy1, done1}, 6'b0);
      end
      start0 = 1'b0; start1 = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // table-driven single-LED frames
      foreach (vecs[i]) begin
         level_g = vecs[i].g; level_r = vecs[i].r; level_b = vecs[i].b;
         start0 = 1'b1;
         measure(0, 24, mask, bad, dk);
         check("vec_mask", mask[23:0], vecs[i].mask);
         check("vec_width_legal", bad, 0);
         check("vec_done_cycle", dk, vecs[i].done_k);
         @(negedge clk);
         check("vec_done_one_cycle", done0, 1'b0);
         repeat (5) @(negedge clk);
      end

      // ignore start while busy, level changes held off, restart in done cycle
      level_g = 8'h12; level_r = 8'h34; level_b = 8'h56;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      dk = 0; cnt_done = 0;
      for (int k = 1; k <= 2000 && dk == 0; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 50) begin level_g = 8'h55; level_r = 8'h55; level_b = 8'h55; end
         if (k == 100) start0 = 1'b1;
         if (k == 101) start0 = 1'b0;
         if (done0) begin cnt_done++; dk = k; end
      end
      check("ignore_done_cycle", dk, 813);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      check("restart_busy", busy0, 1'b1);
      check("restart_dout", dout0, 1'b1);
      dk = 0;
      for (int k = 2; k <= 2000 && dk == 0; k++) begin
         @(negedge clk);
         if (done0) begin cnt_done++; dk = k; end
      end
      check("restart_done_cycle", dk, 813);
      check("ignore_done_pulses", cnt_done, 2);
      repeat (5) @(negedge clk);

      // two-LED chain
      level_g = 8'h0F; level_r = 8'hF0; level_b = 8'h3C;
      start1 = 1'b1;
      measure(1, 48, mask, bad, dk);
      check("chain_mask", mask, 48'h0FF03C0FF03C);
      check("chain_width_legal", bad, 0);
      check("chain_done_cycle", dk, 1125);
      repeat (5) @(negedge clk);

      // reset mid-frame while the line is high
      level_g = 8'h00; level_r = 8'hFF; level_b = 8'h00;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (149) @(negedge clk);
      check("pre_reset_dout", dout0, 1'b1);
      #1 reset = 1'b0;
      #1 check("async_reset", {dout0, busy0, done0}, 3'b000);
      @(negedge clk);
      reset = 1'b1;
      cnt_done = 0; cnt_hi = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         cnt_done += int'(done0);
         cnt_hi   += int'(dout0);
      end
      check("post_reset_done", cnt_done, 0);
      check("post_reset_dout", cnt_hi, 0);

      // random starts and level changes on both instances
      cnt_done = 0;
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         cnt_done += int'(done0) + int'(done1);
         start0 = ($urandom_range(0, 59) == 0);
         start1 = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 19) == 0) begin
            level_g = 8'($urandom); level_r = 8'($urandom); level_b = 8'($urandom);
         end
      end
      start0 = 1'b0; start1 = 1'b0;
      check("random_frames_seen", (cnt_done > 2), 1'b1);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ws2812_driver.md
Name: ws2812_driver

Overview:
- Downstream consumer of the three 8-bit colour levels produced by the encoder stage (red, green, blue channels).
- Serialises the levels into the WS2812 single-wire protocol so one smart RGB LED, or a chain of them, can replace the three discrete PWM outputs.
- Each frame sends the same GRB word to every LED in the chain, then holds the line low for the latch period.

Parameters:
- NUM_LEDS, 1, number of LEDs in the chain; the 24-bit word is repeated this many times per frame.
- T_BIT, 13, clock cycles per data bit. Defaults assume a 10 MHz clk, giving 1.3 us.
- T0H, 4, high cycles for a 0 bit (400 ns).
- T1H, 8, high cycles for a 1 bit (800 ns).
- T_RESET, 500, low cycles of the latch gap after the last bit (50 us).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- level_r  input  8  red level.
- level_g  input  8  green level.
- level_b  input  8  blue level.
- start  input  1  request a frame; sampled on the rising edge of clk.
- dout  output  1  serial data line to the first LED's DIN.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset
  - Asynchronous and active-low: reset=0 forces dout=0, busy=0, done=0, state=IDLE and clears all counters immediately, with no clock required.
  - Applies mid-frame too: the line drops low at once and the partial frame is abandoned (LEDs ignore it once the line has been low for the latch time).
- Frame word
  - word = {level_g, level_r, level_b}, 24 bits, transmitted MSB first (g[7] first, b[0] last).
  - The word is captured into a shift register on the clock edge that accepts start.
  - Changes to the level inputs during a frame have no effect until the next accepted start.
- State machine
  - IDLE: dout=0, busy=0. start=1 at an edge → capture word, bit counter=0, LED counter=0, go to BIT.
  - BIT: cycle counter c runs 0..T_BIT-1. dout=1 while c<TxH and 0 otherwise, where TxH=T1H if the current bit is 1, else T0H. At c=T_BIT-1 advance to the next bit.
  - Word boundary: after bit 23, reload the captured word and increment the LED counter. After bit 23 of LED NUM_LEDS-1, go to LATCH.
  - LATCH: dout=0 for T_RESET cycles, then go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start seen in the DONE cycle is accepted, and the next frame's bit 0 begins on the following cycle.
- Timing
  - busy=1 in every BIT and LATCH cycle.
  - Latency: start sampled at edge E0 → the first BIT cycle (dout=1) is the cycle after E0.
  - BIT runs for 24*NUM_LEDS*T_BIT cycles, followed by T_RESET LATCH cycles.
- start while busy=1 is ignored: it is neither queued nor allowed to restart the frame.
- dout is driven from a register (glitch-free); there is no combinational path from any input to dout.
- Counter sizing: counters must cover T_BIT-1, 24*NUM_LEDS-1 and T_RESET-1 without wrapping.
- Parameter legality: 0<T0H<T1H<T_BIT and NUM_LEDS≥1 are required. Violating values are flagged by a simulation-time error.

Test Plan:
- Reset: hold reset=0 with start=1 and toggle clk → dout=0, busy=0, done=0 throughout. Assert reset=0 between clock edges → outputs go to 0 without waiting for an edge.
- Single frame, NUM_LEDS=1, r=0x00, g=0xFF, b=0x00; start pulses at E0
  - Cycles 1..312: bits 0..7 are 8 high then 5 low; bits 8..23 are 4 high then 9 low.
  - Cycles 313..812: dout=0, busy=1.
  - Cycle 813: done=1, busy=0.
  - done is high for exactly one cycle.
- Bit order: g=0x80, r=0x01, b=0xA5 → measured high widths are 8,4,4,4,4,4,4,4 | 4,4,4,4,4,4,4,8 | 8,4,8,4,4,8,4,8.
- Ignore and hold
  - Pulse start again at cycle 100 and change every level to 0x55 at cycle 50 → no restart; the frame matches the original word; only one done pulse.
  - Then assert start in the done cycle → the new frame (word 0x555555) begins on the next cycle.
- Chain: NUM_LEDS=2, g=0x0F, r=0xF0, b=0x3C → 48 bits in total; the second 24 bits are identical to the first; done at cycle 48*13+500+1=1125.
- Reset mid-frame: reset=0 at cycle 150 while dout=1 → dout=0 and busy=0 asynchronously. After release with no start, dout stays 0 and done never pulses.
